// File: rtl/i2s_pkg.sv
// Shared types and widths for the I2S clock-configuration sequencer.
// The optional fast path is controlled by the I2S_CLKSEQ_FASTPATH_EN macro (see i2s_clkcfg_seq.sv).
package i2s_pkg;

    localparam int DIV_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISABLE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_APPLY   = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_ENABLE  = 3'd5
    } seq_state_t;

    // Bit order matches req_sel_i: [3]=master_num ... [0]=slave_ext.
    typedef struct packed {
        logic master_num;
        logic master_ext;
        logic slave_num;
        logic slave_ext;
    } sel_t;

endpackage

// File: rtl/i2s_seq_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module i2s_seq_cnt
    import i2s_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/i2s_clkcfg_seq.sv
// Glitch-safe reconfiguration of the I2S clock/WS generator: disable, drain, apply, settle, enable.
// Define I2S_CLKSEQ_FASTPATH_EN to let requests that keep divs/sels unchanged skip straight to ENABLE.
module i2s_clkcfg_seq
    import i2s_pkg::*;
#(
    parameter int DRAIN_CYC  = 64,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [DIV_W-1:0] req_div_0_i,
    input  logic [DIV_W-1:0] req_div_1_i,
    input  logic [3:0]       req_sel_i,
    input  logic             req_master_en_i,
    input  logic             req_slave_en_i,
    output logic [DIV_W-1:0] cfg_div_0_o,
    output logic [DIV_W-1:0] cfg_div_1_o,
    output logic             sel_master_num_o,
    output logic             sel_master_ext_o,
    output logic             sel_slave_num_o,
    output logic             sel_slave_ext_o,
    output logic             master_en_o,
    output logic             slave_en_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    seq_state_t       r_state;
    logic [DIV_W-1:0] r_div0_sh, r_div1_sh;
    sel_t             r_sel_sh;
    logic             r_men_sh, r_sen_sh;
    logic [DIV_W-1:0] r_div0, r_div1;
    sel_t             r_sel;
    logic             r_men, r_sen;
    logic             r_done;

    logic w_accept;
    logic w_fast;
    logic w_drain_zero;
    logic w_settle_zero;

    assign w_accept = req_valid_i && (r_state == ST_IDLE);

`ifdef I2S_CLKSEQ_FASTPATH_EN
    assign w_fast = (req_div_0_i == r_div0) && (req_div_1_i == r_div1) && (req_sel_i == r_sel);
`else
    assign w_fast = 1'b0;
`endif

    i2s_seq_cnt u_drain_cnt (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (r_state == ST_DISABLE),
        .i_load_val (DRAIN_LOAD),
        .i_dec      (r_state == ST_DRAIN),
        .o_zero     (w_drain_zero)
    );

    i2s_seq_cnt u_settle_cnt (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_load     (r_state == ST_APPLY),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (r_state == ST_SETTLE),
        .o_zero     (w_settle_zero)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_div0_sh <= '0;
            r_div1_sh <= '0;
            r_sel_sh  <= '0;
            r_men_sh  <= 1'b0;
            r_sen_sh  <= 1'b0;
            r_div0    <= '0;
            r_div1    <= '0;
            r_sel     <= '0;
            r_men     <= 1'b0;
            r_sen     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_div0_sh <= req_div_0_i;
                        r_div1_sh <= req_div_1_i;
                        r_sel_sh  <= sel_t'(req_sel_i);
                        r_men_sh  <= req_master_en_i;
                        r_sen_sh  <= req_slave_en_i;
                        r_state   <= w_fast ? ST_ENABLE : ST_DISABLE;
                    end
                end
                ST_DISABLE: begin
                    r_men   <= 1'b0;
                    r_sen   <= 1'b0;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_drain_zero) r_state <= ST_APPLY;
                end
                ST_APPLY: begin
                    r_div0  <= r_div0_sh;
                    r_div1  <= r_div1_sh;
                    r_sel   <= r_sel_sh;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (w_settle_zero) r_state <= ST_ENABLE;
                end
                ST_ENABLE: begin
                    r_men   <= r_men_sh;
                    r_sen   <= r_sen_sh;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register, so no req_* input reaches an output.
    assign req_ready_o      = (r_state == ST_IDLE);
    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = r_done;
    assign cfg_div_0_o      = r_div0;
    assign cfg_div_1_o      = r_div1;
    assign sel_master_num_o = r_sel.master_num;
    assign sel_master_ext_o = r_sel.master_ext;
    assign sel_slave_num_o  = r_sel.slave_num;
    assign sel_slave_ext_o  = r_sel.slave_ext;
    assign master_en_o      = r_men;
    assign slave_en_o       = r_sen;

endmodule

// File: tb/tb_i2s_clkcfg_seq.sv
// Directed bench for i2s_clkcfg_seq: one instance with DRAIN=4/SETTLE=2, one with DRAIN=1/SETTLE=1.
module tb_i2s_clkcfg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, valid_b;
    logic [15:0] div0, div1;
    logic [3:0]  sel;
    logic        men, sen;

    logic        a_ready, a_men, a_sen, a_busy, a_done;
    logic [15:0] a_div0, a_div1;
    logic        a_smn, a_sme, a_ssn, a_sse;
    logic        b_ready, b_men, b_sen, b_busy, b_done;
    logic [15:0] b_div0, b_div1;
    logic        b_smn, b_sme, b_ssn, b_sse;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    i2s_clkcfg_seq #(.DRAIN_CYC(4), .SETTLE_CYC(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid_a), .req_ready_o(a_ready),
        .req_div_0_i(div0), .req_div_1_i(div1), .req_sel_i(sel),
        .req_master_en_i(men), .req_slave_en_i(sen),
        .cfg_div_0_o(a_div0), .cfg_div_1_o(a_div1),
        .sel_master_num_o(a_smn), .sel_master_ext_o(a_sme),
        .sel_slave_num_o(a_ssn), .sel_slave_ext_o(a_sse),
        .master_en_o(a_men), .slave_en_o(a_sen), .busy_o(a_busy), .done_o(a_done)
    );

    i2s_clkcfg_seq #(.DRAIN_CYC(1), .SETTLE_CYC(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid_b), .req_ready_o(b_ready),
        .req_div_0_i(div0), .req_div_1_i(div1), .req_sel_i(sel),
        .req_master_en_i(men), .req_slave_en_i(sen),
        .cfg_div_0_o(b_div0), .cfg_div_1_o(b_div1),
        .sel_master_num_o(b_smn), .sel_master_ext_o(b_sme),
        .sel_slave_num_o(b_ssn), .sel_slave_ext_o(b_sse),
        .master_en_o(b_men), .slave_en_o(b_sen), .busy_o(b_busy), .done_o(b_done)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [15:0] d0, input logic [15:0] d1, input logic [3:0] s,
                           input logic m, input logic e);
        div0 = d0; div1 = d1; sel = s; men = m; sen = e;
    endtask

    // Ticks until done rises on the chosen instance (bounded); also reports whether master_en dropped.
    task automatic wait_done(input bit which, output int n, output bit men_dropped);
        n = 0;
        men_dropped = 1'b0;
        do begin
            tick();
            n++;
            if (!(which ? b_men : a_men)) men_dropped = 1'b1;
        end while (!(which ? b_done : a_done) && n < 200);
    endtask

    int  lat;
    bit  dropped;
    bit  seen;
    int  exp_fast_lat;
    bit  exp_fast_drop;

    initial begin
        rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        set_req(16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_outs_a", {a_div0, a_div1, a_smn, a_sme, a_ssn, a_sse}, 32'h0);
        check("rst_en_a", {a_men, a_sen, a_busy, a_done}, 4'b0000);
        check("rst_ready_a", a_ready, 1'b1);
        check("rst_outs_b", {b_div0, b_div1, b_smn, b_men, b_busy, b_ready}, {34'h0, 1'b1});

        // Request A: full sequence timing from accept edge T
        set_req(16'h0010, 16'h0000, 4'b0000, 1'b1, 1'b0);
        valid_a = 1'b1;
        tick();                                   // T
        valid_a = 1'b0;
        check("a_busy_T", {a_busy, a_ready}, 2'b10);
        tick();                                   // T+1
        check("a_en_low_T1", a_men, 1'b0);
        repeat (4) tick();                        // T+5
        check("a_div_hold_T5", a_div0, 16'h0000);
        tick();                                   // T+6
        check("a_div_T6", a_div0, 16'h0010);
        repeat (2) tick();                        // T+8
        check("a_nodone_T8", {a_done, a_men}, 2'b00);
        tick();                                   // T+9
        check("a_done_T9", {a_done, a_men, a_sen, a_busy, a_ready}, 5'b11001);
        tick();                                   // T+10
        check("a_done_pulse", a_done, 1'b0);

        // Request B, then C held valid from T+2 while B is in flight
        set_req(16'h0123, 16'h0456, 4'b1010, 1'b1, 1'b1);
        valid_a = 1'b1;
        tick();                                   // T
        valid_a = 1'b0;
        tick();                                   // T+1
        check("b_en_drop", a_men, 1'b0);
        set_req(16'h0AAA, 16'h0BBB, 4'b0101, 1'b0, 1'b1);
        valid_a = 1'b1;
        seen = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (a_ready) seen = 1'b1;
            if (i == 6) begin
                check("b_div_T6", {a_div0, a_div1}, 32'h0123_0456);
                check("b_sel_T6", {a_smn, a_sme, a_ssn, a_sse}, 4'b1010);
            end
        end
        check("bp_ready_low", seen, 1'b0);
        tick();                                   // T+9
        check("b_done", {a_done, a_men, a_sen, a_ready}, 4'b1111);
        check("b_div_kept", a_div0, 16'h0123);
        tick();                                   // T+10: C accepted
        valid_a = 1'b0;
        check("c_accepted", {a_busy, a_ready, a_done}, 3'b100);
        wait_done(1'b0, lat, dropped);
        check("c_latency", lat, 9);
        check("c_div", {a_div0, a_div1}, 32'h0AAA_0BBB);
        check("c_sel", {a_smn, a_sme, a_ssn, a_sse}, 4'b0101);
        check("c_en", {a_men, a_sen}, 2'b01);
        tick();

        // Request D aborted by reset in the middle of DRAIN
        set_req(16'h7777, 16'h1111, 4'b1111, 1'b1, 1'b1);
        valid_a = 1'b1;
        tick();                                   // T
        valid_a = 1'b0;
        repeat (2) tick();                        // T+2
        rst = 1'b1;
        tick();                                   // T+3
        check("rst_mid_outs", {a_div0, a_div1}, 32'h0);
        check("rst_mid_flags", {a_smn, a_sme, a_ssn, a_sse, a_men, a_sen, a_busy, a_done, a_ready}, 9'b000000001);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (a_done || a_busy) seen = 1'b1;
        end
        check("rst_no_done", seen, 1'b0);

        // Request E establishes a configuration; F repeats it with slave enabled
        set_req(16'h0042, 16'h0007, 4'b1100, 1'b1, 1'b0);
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        wait_done(1'b0, lat, dropped);
        check("e_latency", lat, 9);
        check("e_state", {a_div0, a_smn, a_sme, a_ssn, a_sse, a_men, a_sen}, {16'h0042, 6'b110010});
        tick();
        set_req(16'h0042, 16'h0007, 4'b1100, 1'b1, 1'b1);
        valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        wait_done(1'b0, lat, dropped);
`ifdef I2S_CLKSEQ_FASTPATH_EN
        exp_fast_lat  = 1;
        exp_fast_drop = 1'b0;
`else
        exp_fast_lat  = 9;
        exp_fast_drop = 1'b1;
`endif
        check("f_latency", lat, exp_fast_lat);
        check("f_men_dropped", dropped, exp_fast_drop);
        check("f_en", {a_men, a_sen, a_done}, 3'b111);
        tick();

        // Minimum drain/settle on instance B
        set_req(16'h0005, 16'h0001, 4'b0011, 1'b1, 1'b1);
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        wait_done(1'b1, lat, dropped);
        check("min_latency_1", lat, 5);
        check("min_outs_1", {b_div0, b_div1, b_ssn, b_sse, b_men, b_sen}, {32'h0005_0001, 4'b1111});
        tick();
        set_req(16'h00FF, 16'h0002, 4'b0000, 1'b0, 1'b0);
        valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
        wait_done(1'b1, lat, dropped);
        check("min_latency_2", lat, 5);
        check("min_outs_2", {b_div0, b_div1, b_ssn, b_men, b_sen}, {32'h00FF_0002, 3'b000});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_clkcfg_seq.md
I2S_CLKCFG_SEQ -- requirements
Module: i2s_clkcfg_seq

Interface
REQ-001 Parameter DRAIN_CYC, default 64: clk_i cycles held with both enables low before select/divider change, legal range 1..255.
REQ-002 Parameter SETTLE_CYC, default 16: clk_i cycles held after select/divider change before enables are restored, legal range 1..255.
REQ-003 clk_i  in  1  system clock; the only clock of the block.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  1  new configuration request.
REQ-006 req_ready_o  out  1  request accepted when valid&ready are both high on a clk_i edge.
REQ-007 req_div_0_i, req_div_1_i  in  16 each  requested divider values.
REQ-008 req_sel_i  in  4  requested {sel_master_num, sel_master_ext, sel_slave_num, sel_slave_ext}.
REQ-009 req_master_en_i, req_slave_en_i  in  1 each  requested final enables.
REQ-010 cfg_div_0_o, cfg_div_1_o  out  16 each  divider values driven to the clock/WS generator.
REQ-011 sel_master_num_o, sel_master_ext_o, sel_slave_num_o, sel_slave_ext_o  out  1 each  source selects to the generator.
REQ-012 master_en_o, slave_en_o  out  1 each  enables to the generator.
REQ-013 busy_o  out  1  high in every state except IDLE.
REQ-014 done_o  out  1  one-cycle pulse when a request completes.

Function
REQ-015 FSM states: IDLE, DISABLE, DRAIN, APPLY, SETTLE, ENABLE.
REQ-016 req_ready_o = 1 only in IDLE. On accept, the request fields are captured into shadow registers, and the FSM goes to DISABLE.
REQ-017 DISABLE: master_en_o and slave_en_o are cleared. Drain counter is loaded with DRAIN_CYC-1. Next state is DRAIN.
REQ-018 DRAIN: the counter decrements each cycle. At count 0 the FSM goes to APPLY; enables stay low throughout.
REQ-019 APPLY: the shadow divs and sels are copied to the outputs in one cycle. Settle counter is loaded with SETTLE_CYC-1. Next state is SETTLE.
REQ-020 SETTLE: the counter decrements. At 0 the FSM goes to ENABLE.
REQ-021 ENABLE: master_en_o and slave_en_o take the shadow enables, done_o pulses in this cycle, and the next state is IDLE.
REQ-022 Divider and select outputs change only in APPLY. Enable outputs change only in DISABLE and ENABLE, apart from the fast path.
REQ-023 Accept-to-done latency is DRAIN_CYC + SETTLE_CYC + 3 cycles.
REQ-024 A request held valid while busy_o=1 is not accepted. It is accepted in the first IDLE cycle, which is the cycle after done_o. There is no queue.
REQ-025 A request whose divs/sels equal the current outputs still takes the full sequence unless the fast path of REQ-030 is compiled in.
REQ-026 Counters saturate at 0 and never wrap.
REQ-027 Both enables requested 0 is legal: the sequence runs and the outputs stay disabled.

Reset
REQ-028 On rst_i=1 at a clk_i edge, the following values apply and any in-progress sequence is abandoned:
- FSM = IDLE
- all output divs = 0
- all sels = 0
- master_en_o = slave_en_o = 0
- busy_o = done_o = 0
- req_ready_o = 1 from the first cycle after reset deasserts
REQ-029 Shadow registers and counters reset to 0.

Configuration
REQ-030 Macro I2S_CLKSEQ_FASTPATH_EN defined: an accepted request whose divs and sels equal the current outputs goes IDLE->ENABLE directly. Enables update on the next edge, done_o pulses there, latency is 1 cycle, and DRAIN/APPLY/SETTLE are skipped.
REQ-031 Macro undefined: every request takes the full sequence, and no comparison logic is present.

Structure
REQ-032 Shared package i2s_pkg holds:
- the FSM state enum
- the 4-bit select struct {master_num, master_ext, slave_num, slave_ext}
- DIV_W=16
- CNT_W=8
REQ-033 Sub-module i2s_seq_cnt: a loadable 8-bit down-counter with a zero flag, instantiated twice (drain, settle).
REQ-034 All outputs are registered; no combinational path from req_* to outputs.

Verification
REQ-035 Reset: rst_i high for 3 cycles then low -> all outputs 0, req_ready_o=1, busy_o=0.
REQ-036 Full sequence: DRAIN_CYC=4, SETTLE_CYC=2, accept div_0=0x0010, sel=4'b0000, master_en=1 at cycle T -> enables low at T+1, cfg_div_0_o=0x0010 at T+6, master_en_o=1 and done_o at T+9.
REQ-037 Back-pressure: second request held valid from T+2 -> req_ready_o low until done_o, accepted the cycle after done_o, fields of the first request unaffected.
REQ-038 Reset mid-DRAIN: rst_i at T+3 -> next cycle all outputs 0, FSM IDLE, no done_o.
REQ-039 Fast path (macro on): resend identical divs/sels with slave_en=1 -> slave_en_o=1 and done_o one cycle after accept, enables never dropped. With the macro off, the same stimulus takes DRAIN_CYC+SETTLE_CYC+3 cycles.
REQ-040 Boundary: DRAIN_CYC=1, SETTLE_CYC=1 -> done_o exactly 5 cycles after accept; counters never underflow.
